// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the single-cycle core's load/store port and
// the debug/loader port. The CPU has priority, but a pending debug request
// is never refused for more than MAX_WAIT consecutive cycles. In halt mode,
// every memory cycle goes to the debug port.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_be,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    output logic            cpu_halted,
    input  logic            dbg_halt,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [DW-1:0]   dbg_wdata,
    input  logic [DW/8-1:0] dbg_be,
    output logic            dbg_rvalid,
    output logic [DW-1:0]   dbg_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t     state;
    logic [3:0] waitCnt;
    logic       halted;
    logic       starved;
    logic       cpuGnt;
    logic       dbgGnt;

    // Grant decision: a debug request wins when halted, when the CPU is idle,
    // or when it has already been refused MAX_WAIT times in a row.
    // Reset low suppresses every grant.
    always_comb begin
        halted  = (state == HALTED);
        starved = (waitCnt == MaxWait);
        dbgGnt  = reset && dbg_valid && (halted || !cpu_req || starved);
        cpuGnt  = reset && cpu_req && !halted && !dbgGnt;
    end

    assign cpu_stall  = reset && cpu_req && !cpuGnt;
    assign dbg_ready  = dbgGnt;
    assign cpu_halted = halted;
    assign cpu_rdata  = mem_rdata;

    // Memory bus mux: only the granted side reaches the memory. The bus is
    // driven to zero when nothing is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (cpuGnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (dbgGnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_be    = dbg_be;
        end
    end

    // Run/halt state, starvation counter and the registered debug read return.
    // The counter only advances on a refused debug request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            waitCnt    <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state <= dbg_halt ? HALTED : RUN;
            if (halted || dbgGnt || !dbg_valid)
                waitCnt <= '0;
            else if (cpu_req)
                waitCnt <= waitCnt + 4'd1;
            dbg_rvalid <= dbgGnt && !dbg_we;
            if (dbgGnt && !dbg_we)
                dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic checked against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [3:0]    cpu_be;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall, cpu_halted;
    logic          dbg_halt, dbg_valid, dbg_ready, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [3:0]    dbg_be;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_halted(cpu_halted),
        .dbg_halt(dbg_halt), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: 64 words, asynchronous read, byte-masked write at the edge.
    logic [31:0] tbMem [64];
    assign mem_rdata = tbMem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tbMem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    // Reference model state.
    bit          mHalted = 0;
    int          mRefused = 0;
    bit          expRvalid = 0;
    logic [31:0] expRdata = 0;

    // Expected owner of the current cycle: 0 none, 1 CPU, 2 debug.
    function automatic int predict();
        if (!reset) return 0;
        if (mHalted) return dbg_valid ? 2 : 0;
        if (cpu_req && dbg_valid) return (mRefused >= MAX_WAIT) ? 2 : 1;
        if (cpu_req) return 1;
        if (dbg_valid) return 2;
        return 0;
    endfunction

    // Clock one cycle and advance the model with the inputs of that cycle.
    task automatic advance();
        int g;
        logic [31:0] rd;
        g  = predict();
        rd = tbMem[dbg_addr[7:2]];
        @(posedge clk);
        #1;
        if (!reset) begin
            mHalted = 0; mRefused = 0; expRvalid = 0; expRdata = 0;
        end else begin
            expRvalid = (g == 2) && !dbg_we;
            if (expRvalid) expRdata = rd;
            if (mHalted || g == 2 || !dbg_valid) mRefused = 0;
            else if (cpu_req) mRefused++;
            mHalted = dbg_halt;
        end
    endtask

    task automatic idle();
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        dbg_halt = 0; dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 0; cpu_req = 1; cpu_addr = 4; dbg_valid = 1; dbg_addr = 8;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({mem_en, mem_we, dbg_ready, cpu_stall} !== 4'b0) begin
                errors++;
                $display("FAIL rst_outputs cyc %0d got en/we/rdy/stall=%b exp 0000", c, {mem_en, mem_we, dbg_ready, cpu_stall});
            end
            advance();
            checks++;
            if (dbg_rvalid !== 1'b0 || cpu_halted !== 1'b0) begin
                errors++;
                $display("FAIL rst_regs cyc %0d got rvalid=%b halted=%b exp 0 0", c, dbg_rvalid, cpu_halted);
            end
        end
        reset = 1; dbg_valid = 0;
        #1;
        checks++;
        if (cpu_halted !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'd4 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got halted=%b en=%b addr=%0d stall=%b exp 0 1 4 0", cpu_halted, mem_en, mem_addr, cpu_stall);
        end
        advance();
        idle();
    endtask

    task automatic test_cpu_store();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 100; cpu_wdata = 25; cpu_be = 4'hF;
        #1;
        checks++;
        if ({mem_en, mem_we, cpu_stall} !== 3'b110 || mem_addr !== 32'd100 || mem_wdata !== 32'd25) begin
            errors++;
            $display("FAIL cpu_store got en/we/stall=%b addr=%0d data=%0d exp 110 100 25", {mem_en, mem_we, cpu_stall}, mem_addr, mem_wdata);
        end
        advance();
        cpu_we = 0;
        #1;
        checks++;
        if (cpu_rdata !== 32'd25) begin
            errors++;
            $display("FAIL cpu_load got %0d exp 25", cpu_rdata);
        end
        advance();
        idle();
    endtask

    task automatic test_contention();
        idle();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 96; dbg_wdata = 32'hCAFE0096; dbg_be = 4'hF;
        #1;
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cont_preload got ready=%b exp 1", dbg_ready);
        end
        advance();
        dbg_we = 0; cpu_req = 1;
        for (int c = 1; c <= 5; c++) begin
            cpu_addr = 32'(c * 4);
            #1;
            checks++;
            if (cpu_stall !== (c == 5) || dbg_ready !== (c == 5) || mem_addr !== ((c == 5) ? 32'd96 : 32'(c * 4))) begin
                errors++;
                $display("FAIL cont_cyc%0d got stall=%b ready=%b addr=%0d exp %b %b %0d", c, cpu_stall, dbg_ready, mem_addr, c == 5, c == 5, (c == 5) ? 96 : c * 4);
            end
            advance();
        end
        #1;
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hCAFE0096 || cpu_stall !== 1'b0 || dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_return got rvalid=%b rdata=%h stall=%b ready=%b exp 1 cafe0096 0 0", dbg_rvalid, dbg_rdata, cpu_stall, dbg_ready);
        end
        advance();
        idle();
        advance();
    endtask

    task automatic test_halt();
        idle();
        cpu_req = 1; cpu_addr = 8; dbg_halt = 1;
        #1;
        checks++;
        if (cpu_halted !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'd8) begin
            errors++;
            $display("FAIL halt_edge got halted=%b stall=%b addr=%0d exp 0 0 8", cpu_halted, cpu_stall, mem_addr);
        end
        advance();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 96; dbg_wdata = 30; dbg_be = 4'hF;
        #1;
        checks++;
        if ({cpu_halted, cpu_stall, dbg_ready, mem_we} !== 4'b1111 || mem_addr !== 32'd96) begin
            errors++;
            $display("FAIL halt_write got halted/stall/ready/we=%b addr=%0d exp 1111 96", {cpu_halted, cpu_stall, dbg_ready, mem_we}, mem_addr);
        end
        advance();
        dbg_we = 0;
        #1;
        checks++;
        if (dbg_ready !== 1'b1 || dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL halt_read got ready=%b rvalid=%b exp 1 0", dbg_ready, dbg_rvalid);
        end
        advance();
        dbg_valid = 0; dbg_halt = 0;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'd30 || cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_rdata got rvalid=%b rdata=%0d stall=%b en=%b exp 1 30 1 0", dbg_rvalid, dbg_rdata, cpu_stall, mem_en);
        end
        advance();
        #1;
        checks++;
        if (cpu_halted !== 1'b0 || cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'd8) begin
            errors++;
            $display("FAIL halt_resume got halted=%b stall=%b en=%b addr=%0d exp 0 0 1 8", cpu_halted, cpu_stall, mem_en, mem_addr);
        end
        advance();
        idle();
    endtask

    task automatic test_byte_enable();
        idle();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 172; dbg_wdata = 0; dbg_be = 4'hF;
        advance();
        dbg_wdata = 32'hAABBCCEE; dbg_be = 4'b0001;
        #1;
        checks++;
        if (mem_be !== 4'b0001 || mem_wdata !== 32'hAABBCCEE) begin
            errors++;
            $display("FAIL be_bus got be=%b data=%h exp 0001 aabbccee", mem_be, mem_wdata);
        end
        advance();
        dbg_we = 0;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL be_store_rvalid got %b exp 0", dbg_rvalid);
        end
        advance();
        dbg_we = 1; dbg_wdata = 32'hFFFFFFFF; dbg_be = 4'b0000;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h000000EE || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL be_readback got rvalid=%b rdata=%h en=%b exp 1 000000ee 1", dbg_rvalid, dbg_rdata, mem_en);
        end
        advance();
        dbg_we = 0;
        advance();
        dbg_valid = 0;
        #1;
        checks++;
        if (dbg_rdata !== 32'h000000EE) begin
            errors++;
            $display("FAIL be_zero_mask got rdata=%h exp 000000ee", dbg_rdata);
        end
        advance();
        idle();
    endtask

    task automatic test_reset_mid_read();
        idle();
        dbg_valid = 1; dbg_addr = 100;
        advance();
        reset = 0; dbg_valid = 0;
        advance();
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'd0) begin
            errors++;
            $display("FAIL midrd_reset got rvalid=%b rdata=%h exp 0 0", dbg_rvalid, dbg_rdata);
        end
        dbg_valid = 1;
        #1;
        checks++;
        if (dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrd_ready got %b exp 0", dbg_ready);
        end
        advance();
        reset = 1; dbg_valid = 0;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrd_norvalid got %b exp 0", dbg_rvalid);
        end
        advance();
        idle();
    endtask

    task automatic test_random();
        int g;
        logic [73:0] expBus;
        idle();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 59) != 0);
            cpu_req   = ($urandom_range(0, 99) < 70);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            cpu_wdata = $urandom;
            cpu_be    = 4'($urandom_range(0, 15));
            dbg_valid = ($urandom_range(0, 99) < 55);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            dbg_wdata = $urandom;
            dbg_be    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) dbg_halt = ~dbg_halt;
            #1;
            g = predict();
            expBus = '0;
            if (g == 1) expBus = {1'b1, cpu_we, cpu_addr, cpu_wdata, cpu_be};
            if (g == 2) expBus = {1'b1, dbg_we, dbg_addr, dbg_wdata, dbg_be};
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== expBus) begin
                errors++;
                $display("FAIL rnd_bus n=%0d got %h exp %h", n, {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, expBus);
            end
            checks++;
            if ({cpu_stall, dbg_ready, cpu_halted} !== {reset && cpu_req && g != 1, g == 2, mHalted}) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d got stall/ready/halted=%b exp %b", n, {cpu_stall, dbg_ready, cpu_halted}, {reset && cpu_req && g != 1, g == 2, mHalted});
            end
            checks++;
            if (dbg_rvalid !== expRvalid || dbg_rdata !== expRdata) begin
                errors++;
                $display("FAIL rnd_rdata n=%0d got rvalid=%b rdata=%h exp %b %h", n, dbg_rvalid, dbg_rdata, expRvalid, expRdata);
            end
            if (g == 1) begin
                checks++;
                if (cpu_rdata !== tbMem[cpu_addr[7:2]]) begin
                    errors++;
                    $display("FAIL rnd_cpu_rdata n=%0d got %h exp %h", n, cpu_rdata, tbMem[cpu_addr[7:2]]);
                end
            end
            advance();
        end
        idle();
        advance();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbMem[i] = 32'h0;
        test_reset();
        test_cpu_store();
        test_contention();
        test_halt();
        test_byte_enable();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
